// File: rtl/conv_pkg.sv
// Shared types and constants for the 1-D convolution line packer.
package conv_pkg;

   localparam int LINE_D = 640;

   typedef enum logic [1:0] {
      EMPTY,
      FILLING,
      FULL
   } bank_state_t;

   typedef logic [$clog2(LINE_D)-1:0] idx_t;

   // Index width for a line of d entries (at least one bit).
   function automatic int idx_width(input int d);
      return (d > 1) ? $clog2(d) : 1;
   endfunction

endpackage

// File: rtl/conv_line_packer_line_bank.sv
// One line bank: D bytes of storage plus its EMPTY/FILLING/FULL state.
// Contents are zeroed on reset and on release, so a short line reads back
// zero beyond its last written entry.
module line_bank
   import conv_pkg::*;
#(
   parameter int D  = LINE_D,
   parameter int IW = idx_width(D)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_en,
   input  logic [IW-1:0]       wr_idx,
   input  logic signed [7:0]   wr_data,
   input  logic                commit,
   input  logic                rel,
   output bank_state_t         state,
   output logic signed [7:0]   data [D]
);

   bank_state_t       state_q, state_d;
   logic signed [7:0] mem_q [D];
   logic signed [7:0] mem_d [D];

   // Next bank contents and state from write, commit and release requests.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      mem_d   = mem_q;
      if (rel) begin
         state_d = EMPTY;
         for (int i = 0; i < D; i++) mem_d[i] = '0;
      end
      if (wr_en) begin
         mem_d[wr_idx] = wr_data;
         if (state_q == EMPTY) state_d = FILLING;
      end
      if (commit) state_d = FULL;
   end

   // Bank registers with synchronous clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         // NOTE: storage is cleared on reset on purpose: a short line after reset must read zeros, not stale pixels.
         for (int i = 0; i < D; i++) mem_q[i] <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
         state_q <= state_d;
         mem_q   <= mem_d;
      end
   end

   assign state = state_q;
   assign data  = mem_q;

endmodule

// File: rtl/conv_line_packer.sv
// Ping-pong line packer: fills one bank from the pixel stream while the
// other bank is presented whole to the convolution core.
module conv_line_packer
   import conv_pkg::*;
#(
   parameter int D = LINE_D
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic signed [7:0]  s_data,
   input  logic               s_last,
   output logic               m_valid,
   input  logic               m_ready,
   output logic signed [7:0]  m_data [D],
   output logic               err_len,
   output logic [15:0]        line_cnt
);

   localparam int            IW       = idx_width(D);
   localparam logic [IW-1:0] LAST_IDX = IW'(D - 1);

   logic          wr_bank_q, wr_bank_d;
   logic          rd_bank_q, rd_bank_d;
   logic [IW-1:0] wr_idx_q, wr_idx_d;
   logic [15:0]   line_cnt_q, line_cnt_d;
   logic          err_len_q, err_len_d;

   bank_state_t       bank_state [2];
   logic signed [7:0] bank_data [2][D];
   logic [1:0]        bank_wr_en, bank_commit, bank_rel;
   logic              accept, at_end, commit, release_line;

   for (genvar b = 0; b < 2; b++) begin : g_bank
      line_bank #(.D(D), .IW(IW)) u_bank (
         .clk     (clk),
         .rst_n   (rst_n),
         .wr_en   (bank_wr_en[b]),
         .wr_idx  (wr_idx_q),
         .wr_data (s_data),
         .commit  (bank_commit[b]),
         .rel     (bank_rel[b]),
         .state   (bank_state[b]),
         .data    (bank_data[b])
      );
   end

   // Handshake decode and next-state for bank pointers, index, error and count.
   always_comb begin
      s_ready      = (bank_state[wr_bank_q] != FULL);
      m_valid      = (bank_state[rd_bank_q] == FULL);
      accept       = s_valid && s_ready;
      at_end       = (wr_idx_q == LAST_IDX);
      commit       = accept && (at_end || s_last);
      release_line = m_valid && m_ready;

      bank_wr_en              = '0;
      bank_commit             = '0;
      bank_rel                = '0;
      bank_wr_en[wr_bank_q]   = accept;
      bank_commit[wr_bank_q]  = commit;
      bank_rel[rd_bank_q]     = release_line;

      wr_bank_d  = wr_bank_q ^ commit;
      rd_bank_d  = rd_bank_q ^ release_line;
      wr_idx_d   = commit ? '0 : (accept ? wr_idx_q + 1'b1 : wr_idx_q);
      line_cnt_d = line_cnt_q + 16'(release_line);
      // Error when the line ends by index alone or by s_last alone.
      err_len_d  = accept && (at_end != s_last);
   end

   // Control registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         wr_idx_q   <= '0;
         line_cnt_q <= '0;
         err_len_q  <= 1'b0;
      end else begin
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         wr_idx_q   <= wr_idx_d;
         line_cnt_q <= line_cnt_d;
         err_len_q  <= err_len_d;
      end
   end

   // Present the read bank; it holds steady until released.
   always_comb begin
      for (int i = 0; i < D; i++) m_data[i] = bank_data[rd_bank_q][i];
   end

   assign err_len  = err_len_q;
   assign line_cnt = line_cnt_q;

endmodule

// File: tb/tb_conv_line_packer.sv
// Directed and randomized-traffic bench for conv_line_packer (short line length).
module tb_conv_line_packer;

   localparam int D      = 16;
   localparam int W      = D * 8;
   localparam int NLINES = 100;

   logic              clk;
   logic              rst_n;
   logic              s_valid;
   logic              s_ready;
   logic signed [7:0] s_data;
   logic              s_last;
   logic              m_valid;
   logic              m_ready;
   logic signed [7:0] m_data [D];
   logic              err_len;
   logic [15:0]       line_cnt;

   logic [W-1:0]      m_pk;
   logic [W-1:0]      exp_v;
   logic [W-1:0]      exp_lines [NLINES];
   int                checks   = 0;
   int                failures = 0;

   conv_line_packer #(.D(D)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_data   (s_data),
      .s_last   (s_last),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .err_len  (err_len),
      .line_cnt (line_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < D; i++) m_pk[i*8 +: 8] = m_data[i];
   end

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] want);
      checks++;
      assert (obs === want) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, want);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present one beat and hold it until accepted (bounded wait).
   task automatic push(input logic [7:0] d, input logic l);
      int n;
      n       = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      while (!s_ready && n < 200) begin
         tick(1);
         n++;
      end
      if (!s_ready) check("push_timeout", W'(s_ready), W'(1));
      tick(1);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   function automatic logic [W-1:0] ramp(input int base);
      logic [W-1:0] r;
      for (int i = 0; i < D; i++) r[i*8 +: 8] = 8'(base + i);
      return r;
   endfunction

   initial begin
      s_valid = 1'b0;
      s_data  = '0;
      s_last  = 1'b0;
      m_ready = 1'b0;
      rst_n   = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);

      // Reset state
      check("rst_s_ready",  W'(s_ready),  W'(1));
      check("rst_m_valid",  W'(m_valid),  W'(0));
      check("rst_line_cnt", W'(line_cnt), W'(0));
      check("rst_err_len",  W'(err_len),  W'(0));
      check("rst_m_data",   m_pk,         '0);

      // Full ramp line, latency one cycle after the last beat
      for (int i = 0; i < D - 1; i++) push(8'(i), 1'b0);
      check("ramp_pre_last_m_valid", W'(m_valid), W'(0));
      push(8'(D - 1), 1'b1);
      check("ramp_m_valid", W'(m_valid), W'(1));
      check("ramp_err_len", W'(err_len), W'(0));
      check("ramp_m_data",  m_pk,        ramp(0));
      m_ready = 1'b1;
      tick(1);
      m_ready = 1'b0;
      check("ramp_line_cnt", W'(line_cnt), W'(1));
      check("ramp_released", W'(m_valid),  W'(0));
      check("ramp_s_ready",  W'(s_ready),  W'(1));

      // Three lines with consumer stalled
      for (int i = 0; i < D; i++) push(8'(10 + i), i == D - 1);
      check("A_s_ready", W'(s_ready), W'(1));
      check("A_m_valid", W'(m_valid), W'(1));
      for (int i = 0; i < D; i++) push(8'(20 + i), i == D - 1);
      check("B_s_ready_low", W'(s_ready), W'(0));
      check("B_m_data_is_A", m_pk,        ramp(10));
      s_valid = 1'b1;
      s_data  = 8'd30;
      s_last  = 1'b0;
      tick(3);
      check("stall_s_ready", W'(s_ready), W'(0));
      check("stall_hold_A",  m_pk,        ramp(10));
      m_ready = 1'b1;
      tick(1);
      m_ready = 1'b0;
      check("after_rel_s_ready",  W'(s_ready),  W'(1));
      check("after_rel_m_data_B", m_pk,         ramp(20));
      check("after_rel_line_cnt", W'(line_cnt), W'(2));
      for (int i = 0; i < D; i++) push(8'(30 + i), i == D - 1);
      check("C_hold_B",      m_pk,       ramp(20));
      check("C_s_ready_low", W'(s_ready), W'(0));
      m_ready = 1'b1;
      tick(1);
      check("rel_B_line_cnt", W'(line_cnt), W'(3));
      check("rel_B_m_data_C", m_pk,         ramp(30));
      tick(1);
      m_ready = 1'b0;
      check("rel_C_line_cnt", W'(line_cnt), W'(4));
      check("rel_C_m_valid",  W'(m_valid),  W'(0));

      // Short line: five beats of -3
      for (int i = 0; i < 4; i++) push(8'hFD, 1'b0);
      check("short_pre_err", W'(err_len), W'(0));
      push(8'hFD, 1'b1);
      exp_v = '0;
      for (int i = 0; i < 5; i++) exp_v[i*8 +: 8] = 8'hFD;
      check("short_err_pulse", W'(err_len), W'(1));
      check("short_m_valid",   W'(m_valid), W'(1));
      check("short_m_data",    m_pk,        exp_v);
      tick(1);
      check("short_err_clear", W'(err_len), W'(0));
      m_ready = 1'b1;
      tick(1);
      m_ready = 1'b0;
      check("short_line_cnt", W'(line_cnt), W'(5));

      // Missing s_last: commit at index D-1 anyway
      for (int i = 0; i < D; i++) push(8'(8'h40 + i), 1'b0);
      check("nolast_err_pulse", W'(err_len), W'(1));
      check("nolast_m_valid",   W'(m_valid), W'(1));
      check("nolast_m_data",    m_pk,        ramp(8'h40));
      tick(1);
      check("nolast_err_clear", W'(err_len), W'(0));
      for (int i = 0; i < D; i++) push(8'(8'h50 + i), i == D - 1);
      check("nextline_no_err", W'(err_len), W'(0));
      m_ready = 1'b1;
      tick(1);
      check("nextline_m_data",   m_pk,         ramp(8'h50));
      check("nextline_cnt_6",    W'(line_cnt), W'(6));
      tick(1);
      m_ready = 1'b0;
      check("nextline_cnt_7",    W'(line_cnt), W'(7));
      check("nextline_m_valid",  W'(m_valid),  W'(0));

      // Reset while a line is presented and another is half written
      for (int i = 0; i < D; i++) push(8'(8'h70 + i), i == D - 1);
      check("prerst_m_valid", W'(m_valid), W'(1));
      for (int i = 0; i < D / 2; i++) push(8'(8'h90 + i), 1'b0);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      check("midrst_m_valid",  W'(m_valid),  W'(0));
      check("midrst_s_ready",  W'(s_ready),  W'(1));
      check("midrst_line_cnt", W'(line_cnt), W'(0));
      check("midrst_err_len",  W'(err_len),  W'(0));
      check("midrst_m_data",   m_pk,         '0);
      push(8'h01, 1'b0);
      push(8'h02, 1'b0);
      push(8'h03, 1'b1);
      exp_v = '0;
      exp_v[7:0]   = 8'h01;
      exp_v[15:8]  = 8'h02;
      exp_v[23:16] = 8'h03;
      check("postrst_no_residue", m_pk, exp_v);
      m_ready = 1'b1;
      tick(1);
      m_ready = 1'b0;
      check("postrst_line_cnt", W'(line_cnt), W'(1));

      // Randomized valid/ready traffic over many lines
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      for (int l = 0; l < NLINES; l++) begin
         for (int i = 0; i < D; i++) exp_lines[l][i*8 +: 8] = 8'($urandom_range(0, 255));
      end
      fork
         begin
            for (int l = 0; l < NLINES; l++) begin
               for (int i = 0; i < D; i++) begin
                  tick($urandom_range(0, 2));
                  push(exp_lines[l][i*8 +: 8], i == D - 1);
               end
            end
         end
         begin
            int rx;
            int cyc;
            rx  = 0;
            cyc = 0;
            while (rx < NLINES && cyc < 20000) begin
               m_ready = 1'($urandom_range(0, 1));
               if (m_valid && m_ready) begin
                  check($sformatf("rand_line_%0d", rx), m_pk, exp_lines[rx]);
                  rx++;
               end
               tick(1);
               cyc++;
            end
            m_ready = 1'b0;
            check("rand_rx_count", W'(rx), W'(NLINES));
         end
      join
      check("rand_line_cnt", W'(line_cnt), W'(NLINES));
      check("rand_m_valid",  W'(m_valid),  W'(0));
      check("rand_s_ready",  W'(s_ready),  W'(1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
